// File: rtl/core_pkg.sv
// Shared core definitions: datapath sizes, opcode/func constants, writeback FSM and halt-cause enums.
package core_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [2:0] FUNC_ADD   = 3'b000;
  localparam logic [2:0] FUNC_SLL   = 3'b001;
  localparam logic [2:0] FUNC_XOR   = 3'b100;
  localparam logic [2:0] FUNC_OR    = 3'b110;
  localparam logic [2:0] FUNC_AND   = 3'b111;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_EXEC_ERR = 2'b01,
    CAUSE_MISALIGN = 2'b10
  } halt_cause_t;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } wb_state_t;

endpackage

// File: rtl/writeback_pc_unit_if.sv
// Execute -> writeback result bus. master = execute stage, slave = writeback_pc_unit.
interface writeback_pc_unit_if;
  import core_pkg::*;

  logic            valid_wb;
  logic [XLEN-1:0] sonuc_wb;
  logic            pc_update_wb;
  logic            we_wb;
  logic            hata_wb;
  logic            branch_wb;
  logic [4:0]      rd_addr;

  modport master (
    output valid_wb, sonuc_wb, pc_update_wb, we_wb, hata_wb, branch_wb, rd_addr
  );

  modport slave (
    input valid_wb, sonuc_wb, pc_update_wb, we_wb, hata_wb, branch_wb, rd_addr
  );
endinterface

// File: rtl/writeback_pc_unit_regfile.sv
// regfile_2r1w: two asynchronous read ports, one synchronous write port, x0 hard-wired to zero.
module regfile_2r1w #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] regs [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  // No write bypass: a same-cycle read returns the pre-edge contents.
  assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule

// File: rtl/writeback_pc_unit.sv
// Writeback/PC unit: owns PC, register file and RUN/HALT state.
// Optional WB_PERF_CNT_EN adds the retired_cnt output.
module writeback_pc_unit
  import core_pkg::*;
#(
  parameter int unsigned      XLEN     = core_pkg::XLEN,
  parameter int unsigned      NREGS    = core_pkg::NREGS,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  writeback_pc_unit_if.slave    wb,
  input  logic [4:0]            rs1_addr,
  input  logic [4:0]            rs2_addr,
  input  logic                  halt_clr,
  output logic [XLEN-1:0]       rs1_data,
  output logic [XLEN-1:0]       rs2_data,
  output logic [XLEN-1:0]       pc,
  output logic                  halted,
  output logic [1:0]            halt_cause
`ifdef WB_PERF_CNT_EN
  ,
  output logic [31:0]           retired_cnt
`endif
);

  wb_state_t       state;
  halt_cause_t     cause;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] pc_plus4;
  logic            accept;
  logic            misalign;
  logic            commit;
  logic            reg_we;

  assign target   = pc + wb.sonuc_wb;
  assign pc_plus4 = pc + XLEN'(4);
  assign accept   = (state == RUN) && wb.valid_wb;
  assign misalign = wb.pc_update_wb && (target[1:0] != 2'b00);
  assign commit   = accept && !wb.hata_wb && !misalign;
  // A taken branch also suppresses the write, so a branch with we_wb=1 never lands in the file.
  assign reg_we   = commit && wb.we_wb && !wb.branch_wb && !wb.pc_update_wb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cause <= CAUSE_NONE;
      pc    <= RESET_PC;
    end else begin
      case (state)
        RUN: begin
          if (accept) begin
            if (wb.hata_wb) begin
              state <= HALT;
              cause <= CAUSE_EXEC_ERR;
            end else if (misalign) begin
              state <= HALT;
              cause <= CAUSE_MISALIGN;
            end else begin
              pc <= wb.pc_update_wb ? target : pc_plus4;
            end
          end
        end
        HALT: begin
          if (halt_clr) begin
            state <= RUN;
            cause <= CAUSE_NONE;
            pc    <= RESET_PC;
          end
        end
        default: begin
          state <= HALT;
        end
      endcase
    end
  end

  assign halted     = (state == HALT);
  assign halt_cause = cause;

`ifdef WB_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_cnt <= '0;
    end else if ((state == HALT) && halt_clr) begin
      retired_cnt <= '0;
    end else if (commit) begin
      retired_cnt <= retired_cnt + 32'd1;
    end
  end
`endif

  regfile_2r1w #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (reg_we),
    .waddr  (wb.rd_addr),
    .wdata  (wb.sonuc_wb),
    .raddr1 (rs1_addr),
    .raddr2 (rs2_addr),
    .rdata1 (rs1_data),
    .rdata2 (rs2_data)
  );

endmodule
